// File: rtl/dbg_telemetry_tx.sv
// Debug telemetry transmitter: snapshots the mimosa debug fields on a trigger and
// sends an 18-byte 8N1 frame (sync, 16 data bytes, XOR checksum) on one wire.
module dbg_telemetry_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned AUTO_PERIOD  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [6:0]  dbg_cortisol,
    input  logic [6:0]  dbg_dopamine,
    input  logic [6:0]  dbg_gaba,
    input  logic [6:0]  dbg_norepinephrine,
    input  logic [6:0]  dbg_serotonin,
    input  logic [15:0] dbg_stimuli,
    input  logic [9:0]  dbg_neurotransmitter_level,
    input  logic [7:0]  dbg_emotional_state,
    input  logic [7:0]  dbg_action,
    input  logic [7:0]  dbg_nourishment,
    input  logic [7:0]  dbg_vital_energy,
    input  logic [1:0]  dbg_heartbeat,
    input  logic [8:0]  dbg_illness,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);
    localparam logic [4:0]  BYTE_LAST = 5'd17;

    state_t            state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [4:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       auto_cnt_q, auto_cnt_d;
    logic [15:0][7:0]  snap_q, snap_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic [15:0][7:0]  capture;
    logic [7:0]        checksum;
    logic [7:0]        cur_byte;
    logic              baud_last;
    logic              auto_fire;

    // Entry i holds frame byte i+1, already zero-extended.
    always_comb begin
        capture[0]  = {1'b0, dbg_cortisol};
        capture[1]  = {1'b0, dbg_dopamine};
        capture[2]  = {1'b0, dbg_gaba};
        capture[3]  = {1'b0, dbg_norepinephrine};
        capture[4]  = {1'b0, dbg_serotonin};
        capture[5]  = dbg_stimuli[15:8];
        capture[6]  = dbg_stimuli[7:0];
        capture[7]  = {6'b0, dbg_neurotransmitter_level[9:8]};
        capture[8]  = dbg_neurotransmitter_level[7:0];
        capture[9]  = dbg_emotional_state;
        capture[10] = dbg_action;
        capture[11] = {6'b0, dbg_heartbeat};
        capture[12] = dbg_nourishment;
        capture[13] = dbg_vital_energy;
        capture[14] = {7'b0, dbg_illness[8]};
        capture[15] = dbg_illness[7:0];
    end

    // NOTE: blocking '=' is right here because this is combinational; the accumulator
    // must see its own update within the loop. Sequential state uses '<=' only.
    always_comb begin
        checksum = '0;
        for (int i = 0; i < 16; i++) begin
            checksum ^= snap_q[i];
        end
    end

    // Byte indices 1..16 map onto snapshot entries 0..15 through 4-bit wraparound.
    always_comb begin
        if (byte_idx_q == 5'd0) begin
            cur_byte = SYNC_BYTE;
        end else if (byte_idx_q == BYTE_LAST) begin
            cur_byte = checksum;
        end else begin
            cur_byte = snap_q[byte_idx_q[3:0] - 4'd1];
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);
    assign auto_fire = (AUTO_PERIOD != 0) && (auto_cnt_q == AUTO_LAST);

    // NOTE: every _d signal gets a default before the case so that no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        auto_cnt_d   = auto_cnt_q;
        snap_d       = snap_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_last ? 16'd0 : baud_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (trigger || auto_fire) begin
                    state_d    = S_START;
                    snap_d     = capture;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    baud_d     = 16'd0;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 5'd0;
                    auto_cnt_d = 32'd0;
                end else if (AUTO_PERIOD != 0) begin
                    auto_cnt_d = auto_cnt_q + 32'd1;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    if (byte_idx_q < BYTE_LAST) begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 5'd1;
                        tx_d       = 1'b0;
                    end else begin
                        state_d      = S_IDLE;
                        byte_idx_d   = 5'd0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the snapshot is an ordinary register bank, not a RAM, so it is reset along
    // with everything else; a cleared snapshot keeps the checksum defined after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            auto_cnt_q   <= '0;
            snap_q       <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            auto_cnt_q   <= auto_cnt_d;
            snap_q       <= snap_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
